dcntr8: RTL and testbench

- Loadable down-counter with an explicit state machine. It is the decrement-direction counterpart of the team's up-counting cntr8.
- Used as a countdown/timeout source: software or an upstream FSM loads a start value, then pulses or holds dec until zero.
- Exposes its current FSM state on o_state, plus zero and borrow flags, for downstream sequencing.

---
 rtl/dcntr8.sv | 83 ++++++++
 tb/tb_dcntr8.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcntr8.sv
// dcntr8: loadable down-counter with an explicit FSM, zero and borrow flags.
// Define DCNTR8_SATURATE_EN to clamp at zero instead of wrapping (borrow then stays 0).
module dcntr8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic             dbl,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic [2:0]       o_state,
    output logic             zero,
    output logic             borrow
);

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        LOAD = 3'b001,
        DEC1 = 3'b010,
        DEC2 = 3'b011,
        HOLD = 3'b100
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             zero_q, zero_d;
    logic             borrow_q, borrow_d;

    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] diff;
    logic             wrap;

    assign step = dbl ? WIDTH'(2) : WIDTH'(1);
    assign diff = count_q - step;
    assign wrap = (count_q < step);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        borrow_d = 1'b0;
        // Illegal codes recover to IDLE without disturbing the count.
        if (!(state_q inside {IDLE, LOAD, DEC1, DEC2, HOLD})) begin
            state_d = IDLE;
        end else if (load) begin
            state_d = LOAD;
            count_d = d_in;
        end else if (dec) begin
            state_d = dbl ? DEC2 : DEC1;
`ifdef DCNTR8_SATURATE_EN
            count_d = wrap ? '0 : diff;
`else
            count_d  = diff;
            borrow_d = wrap;
`endif
        end else if (state_q != IDLE) begin
            state_d = HOLD;
        end
        // zero tracks the value being registered, not a decode of d_out.
        zero_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            zero_q   <= 1'b1;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            zero_q   <= zero_d;
            borrow_q <= borrow_d;
        end
    end

    assign d_out   = count_q;
    assign o_state = state_q;
    assign zero    = zero_q;
    assign borrow  = borrow_q;

endmodule

// File: tb/tb_dcntr8.sv
// Directed self-checking bench for dcntr8; expected values are hand-computed per scenario.
module tb_dcntr8;

    logic       clk;
    logic       reset;
    logic       load;
    logic       dec;
    logic       dbl;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic [2:0] o_state;
    logic       zero;
    logic       borrow;

    int checks = 0;
    int errors = 0;

    dcntr8 #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .dec     (dec),
        .dbl     (dbl),
        .d_in    (d_in),
        .d_out   (d_out),
        .o_state (o_state),
        .zero    (zero),
        .borrow  (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling outputs.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0;
        load  = 1'b0;
        dec   = 1'b0;
        dbl   = 1'b0;
        d_in  = 8'h00;
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        d_in = v;
        cyc();
        load = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] exp_v;
        reset = 1'b1;
        cyc();
        cyc();
        exp_v = {8'h00, 3'b000, 1'b1, 1'b0};
        checks++;
        if ({d_out, o_state, zero, borrow} !== exp_v) begin
            errors++;
            $display("FAIL reset_held got %h/%b/%b/%b want %h", d_out, o_state, zero, borrow, exp_v);
        end
        reset = 1'b0;
        cyc();
        checks++;
        if ({d_out, o_state, zero, borrow} !== exp_v) begin
            errors++;
            $display("FAIL reset_idle got %h/%b/%b/%b want %h", d_out, o_state, zero, borrow, exp_v);
        end
    endtask

    task automatic test_load_hold();
        logic [12:0] exp_v;
        do_load(8'h44);
        exp_v = {8'h44, 3'b001, 1'b0, 1'b0};
        checks++;
        if ({d_out, o_state, zero, borrow} !== exp_v) begin
            errors++;
            $display("FAIL load_44 got %h/%b/%b/%b want %h", d_out, o_state, zero, borrow, exp_v);
        end
        cyc();
        exp_v = {8'h44, 3'b100, 1'b0, 1'b0};
        checks++;
        if ({d_out, o_state, zero, borrow} !== exp_v) begin
            errors++;
            $display("FAIL hold_44 got %h/%b/%b/%b want %h", d_out, o_state, zero, borrow, exp_v);
        end
        do_load(8'h00);
        exp_v = {8'h00, 3'b001, 1'b1, 1'b0};
        checks++;
        if ({d_out, o_state, zero, borrow} !== exp_v) begin
            errors++;
            $display("FAIL load_zero got %h/%b/%b/%b want %h", d_out, o_state, zero, borrow, exp_v);
        end
    endtask

    task automatic test_dec1();
        logic [7:0] ev[4];
        logic       ez[4];
        logic       eb[4];
        logic [12:0] exp_v;
`ifdef DCNTR8_SATURATE_EN
        ev = '{8'h02, 8'h01, 8'h00, 8'h00};
        ez = '{1'b0, 1'b0, 1'b1, 1'b1};
        eb = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        ev = '{8'h02, 8'h01, 8'h00, 8'hFF};
        ez = '{1'b0, 1'b0, 1'b1, 1'b0};
        eb = '{1'b0, 1'b0, 1'b0, 1'b1};
`endif
        do_load(8'h03);
        dec = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            exp_v = {ev[i], 3'b010, ez[i], eb[i]};
            checks++;
            if ({d_out, o_state, zero, borrow} !== exp_v) begin
                errors++;
                $display("FAIL dec1_step%0d got %h/%b/%b/%b want %h", i, d_out, o_state, zero, borrow, exp_v);
            end
        end
        dec = 1'b0;
        cyc();
        exp_v = {ev[3], 3'b100, ez[3], 1'b0};
        checks++;
        if ({d_out, o_state, zero, borrow} !== exp_v) begin
            errors++;
            $display("FAIL dec1_hold got %h/%b/%b/%b want %h", d_out, o_state, zero, borrow, exp_v);
        end
    endtask

    task automatic test_dec2();
        logic [7:0] ev[3];
        logic       ez[3];
        logic       eb[3];
        logic [12:0] exp_v;
`ifdef DCNTR8_SATURATE_EN
        ev = '{8'h03, 8'h01, 8'h00};
        ez = '{1'b0, 1'b0, 1'b1};
        eb = '{1'b0, 1'b0, 1'b0};
`else
        ev = '{8'h03, 8'h01, 8'hFF};
        ez = '{1'b0, 1'b0, 1'b0};
        eb = '{1'b0, 1'b0, 1'b1};
`endif
        do_load(8'h05);
        dec = 1'b1;
        dbl = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            exp_v = {ev[i], 3'b011, ez[i], eb[i]};
            checks++;
            if ({d_out, o_state, zero, borrow} !== exp_v) begin
                errors++;
                $display("FAIL dec2_step%0d got %h/%b/%b/%b want %h", i, d_out, o_state, zero, borrow, exp_v);
            end
        end
        dec = 1'b0;
        dbl = 1'b0;
        cyc();
    endtask

    task automatic test_dbl_toggle();
        logic [7:0] ev[4];
        logic [2:0] es[4];
        logic       sel[4];
        logic [12:0] exp_v;
        ev  = '{8'h08, 8'h07, 8'h05, 8'h04};
        es  = '{3'b011, 3'b010, 3'b011, 3'b010};
        sel = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_load(8'h0A);
        dec = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dbl = sel[i];
            cyc();
            exp_v = {ev[i], es[i], 1'b0, 1'b0};
            checks++;
            if ({d_out, o_state, zero, borrow} !== exp_v) begin
                errors++;
                $display("FAIL dbl_toggle%0d got %h/%b/%b/%b want %h", i, d_out, o_state, zero, borrow, exp_v);
            end
        end
        dec = 1'b0;
        dbl = 1'b0;
    endtask

    task automatic test_priority();
        logic [12:0] exp_v;
        load = 1'b1;
        dec  = 1'b1;
        dbl  = 1'b1;
        d_in = 8'h10;
        cyc();
        exp_v = {8'h10, 3'b001, 1'b0, 1'b0};
        checks++;
        if ({d_out, o_state, zero, borrow} !== exp_v) begin
            errors++;
            $display("FAIL prio_load got %h/%b/%b/%b want %h", d_out, o_state, zero, borrow, exp_v);
        end
        reset = 1'b1;
        cyc();
        exp_v = {8'h00, 3'b000, 1'b1, 1'b0};
        checks++;
        if ({d_out, o_state, zero, borrow} !== exp_v) begin
            errors++;
            $display("FAIL prio_reset got %h/%b/%b/%b want %h", d_out, o_state, zero, borrow, exp_v);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        logic [7:0] ev[3];
        logic [12:0] exp_v;
        ev = '{8'h1F, 8'h1E, 8'h1D};
        do_load(8'h20);
        dec = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            exp_v = {ev[i], 3'b010, 1'b0, 1'b0};
            checks++;
            if ({d_out, o_state, zero, borrow} !== exp_v) begin
                errors++;
                $display("FAIL mid_dec%0d got %h/%b/%b/%b want %h", i, d_out, o_state, zero, borrow, exp_v);
            end
        end
        reset = 1'b1;
        cyc();
        exp_v = {8'h00, 3'b000, 1'b1, 1'b0};
        checks++;
        if ({d_out, o_state, zero, borrow} !== exp_v) begin
            errors++;
            $display("FAIL mid_reset got %h/%b/%b/%b want %h", d_out, o_state, zero, borrow, exp_v);
        end
        reset = 1'b0;
        cyc();
`ifdef DCNTR8_SATURATE_EN
        exp_v = {8'h00, 3'b010, 1'b1, 1'b0};
`else
        exp_v = {8'hFF, 3'b010, 1'b0, 1'b1};
`endif
        checks++;
        if ({d_out, o_state, zero, borrow} !== exp_v) begin
            errors++;
            $display("FAIL mid_resume got %h/%b/%b/%b want %h", d_out, o_state, zero, borrow, exp_v);
        end
        idle_inputs();
        cyc();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_load_hold();
        test_dec1();
        test_dec2();
        test_dbl_toggle();
        test_priority();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
